// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes and applies the sign correction once, when the result is written.
module mul_seq #(
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_stall,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op,
    input  logic [ITER-1:0] op1,
    input  logic [ITER-1:0] op2,
    output logic [ITER-1:0] op_out
);

    localparam int W  = ITER;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic           neg_q, neg_d;
    logic           hi_sel_q, hi_sel_d;
    logic [W-1:0]   op_out_q, op_out_d;

    logic           accept;
    logic           signed1, signed2, neg1, neg2;
    logic [W-1:0]   mag1, mag2;
    logic [W-1:0]   addend;
    logic [W:0]     sum;
    logic [2*W-1:0] product;

    // MUL/MULH treat both operands as signed, MULHSU only rs1, MULHU neither.
    assign signed1 = (op[1:0] != 2'b11);
    assign signed2 = ~op[1];
    assign neg1    = signed1 & op1[W-1];
    assign neg2    = signed2 & op2[W-1];
    assign mag1    = neg1 ? (~op1 + W'(1)) : op1;
    assign mag2    = neg2 ? (~op2 + W'(1)) : op2;

    assign accept  = (state_q == IDLE) && op_valid && !op_stall && !op[2];

    // Partial product for this iteration: multiplicand gated by multiplier LSB.
    for (genvar gi = 0; gi < W; gi++) begin : g_addend
        assign addend[gi] = mcand_q[gi] & mplier_q[0];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_sel_d = hi_sel_q;
        op_out_d = op_out_q;
        op_ready = 1'b0;
        sum      = '0;
        product  = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mcand_d  = mag1;
                    mplier_d = mag2;
                    neg_d    = neg1 ^ neg2;
                    hi_sel_d = (op != 3'b000);
                    count_d  = CW'(ITER);
                    acc_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Carry out of the high half shifts into bit 2W-1.
                sum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
                acc_d    = {sum, acc_q[W-1:1]};
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d  = DONE;
                    product  = neg_q ? -acc_d : acc_d;
                    op_out_d = hi_sel_q ? product[2*W-1:W] : product[W-1:0];
                end
            end
            DONE: begin
                op_ready = !op_stall;
                if (!op_stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_sel_q <= 1'b0;
            op_out_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_sel_q <= hi_sel_d;
            op_out_q <= op_out_d;
        end
    end

    assign op_out = op_out_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver queues expected results and completion cycles,
// a negedge monitor pops and compares on every op_ready pulse.
module tb_mul_seq;

    logic        clk;
    logic        rst;
    logic        op_stall;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op_out;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    mul_seq #(.ITER(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_stall (op_stall),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .op1      (op1),
        .op2      (op2),
        .op_out   (op_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every op_ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (op_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready cycle=%0d op_out=%h required no op_ready", cyc, op_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                txn++;
                checks += 2;
                $display("txn %0d: cycle=%0d op_out=%h expected cycle=%0d value=%h",
                         txn, cyc, op_out, e.cyc, e.val);
                if (op_out !== e.val) begin
                    errors++;
                    $display("FAIL result txn=%0d got=%h required=%h", txn, op_out, e.val);
                end
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ready_cycle txn=%0d got=%0d required=%0d", txn, cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // One op from IDLE; optional stall held for stall_n cycles starting at T+33.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_v, input int stall_n);
        int t;
        t        = cyc;
        op_valid = 1'b1;
        op       = f;
        op1      = a;
        op2      = b;
        push(exp_v, t + 33 + stall_n);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'b001;
        op1      = $urandom;
        op2      = $urandom;
        if (stall_n > 0) begin
            wait_until(t + 33);
            op_stall = 1'b1;
            wait_until(t + 33 + stall_n);
            op_stall = 1'b0;
        end
        wait_until(t + 34 + stall_n);
    endtask

    task automatic check_direct(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else begin
            $display("check %s: %h", name, got);
        end
    endtask

    initial begin
        int t;
        rst      = 1'b1;
        op_stall = 1'b0;
        op_valid = 1'b0;
        op       = 3'b000;
        op1      = '0;
        op2      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_direct("reset_op_ready", {31'b0, op_ready}, 32'h0);
        check_direct("reset_op_out", op_out, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        issue(F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        issue(F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        issue(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(F_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        issue(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        issue(F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        issue(F_MULH,   32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0);
        issue(F_MUL,    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
        issue(F_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 5);

        // Codes with op[2]=1 are never accepted; the monitor flags any ready.
        op_valid = 1'b1;
        op       = 3'b100;
        op1      = 32'h0000_0003;
        op2      = 32'h0000_0005;
        t        = cyc;
        wait_until(t + 4);
        op_valid = 1'b0;
        wait_until(t + 40);

        // Stall in IDLE blocks accept; the op is taken once stall drops.
        op_valid = 1'b1;
        op_stall = 1'b1;
        op       = F_MUL;
        op1      = 32'h0000_0009;
        op2      = 32'h0000_0009;
        t        = cyc;
        wait_until(t + 3);
        op_stall = 1'b0;
        issue(F_MUL, 32'h0000_0009, 32'h0000_0009, 32'h0000_0051, 0);

        // op_valid held high, operands changed during BUSY, stall pulsed in BUSY.
        t        = cyc;
        op_valid = 1'b1;
        op       = F_MUL;
        op1      = 32'h0000_1234;
        op2      = 32'h0000_0010;
        push(32'h0001_2340, t + 33);
        @(posedge clk);
        #1;
        op       = F_MULHU;
        op1      = 32'hFFFF_FFFF;
        op2      = 32'h0000_0002;
        push(32'h0000_0001, t + 67);
        wait_until(t + 5);
        op_stall = 1'b1;
        wait_until(t + 9);
        op_stall = 1'b0;
        wait_until(t + 35);
        op_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        wait_until(t + 68);

        // Reset mid-operation discards the op and clears op_out.
        t        = cyc;
        op_valid = 1'b1;
        op       = F_MULHU;
        op1      = 32'hFFFF_FFFF;
        op2      = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        wait_until(t + 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_direct("post_rst_op_out", op_out, 32'h0);
        check_direct("post_rst_op_ready", {31'b0, op_ready}, 32'h0);
        wait_until(t + 12);
        issue(F_MUL, 32'h0000_0005, 32'h0000_0006, 32'h0000_001E, 0);
        wait_until(cyc + 3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results got=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog cycle=%0d required completion before timeout", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
